// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one command in, one CYC/STB cycle out, one response back.
// A down-counting watchdog closes any bus cycle the responder never acknowledges.
`timescale 1ns/1ps

module wb_cmd_master #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic          cmd_we_i,
   input  logic [AW-1:0] cmd_adr_i,
   input  logic [DW-1:0] cmd_dat_i,
   output logic          rsp_valid_o,
   input  logic          rsp_ready_i,
   output logic [DW-1:0] rsp_dat_o,
   output logic          rsp_err_o,
   output logic          rsp_tmo_o,
   output logic          CYC_O,
   output logic          STB_O,
   output logic          WE_O,
   output logic [AW-1:0] ADR_O,
   output logic [DW-1:0] DAT_O,
   input  logic          ACK_I,
   input  logic          ERR_I,
   input  logic [DW-1:0] DAT_I
);

   // state | meaning
   // IDLE  | ready for a command, bus idle
   // BUS   | CYC/STB asserted, waiting for ACK/ERR or watchdog expiry
   // RESP  | response presented, waiting for rsp_ready_i
   typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

   // Loaded with TIMEOUT-1 so that terminal count lands on the TIMEOUT-th strobe cycle.
   localparam logic [15:0] WDT_LOAD = 16'(TIMEOUT - 1);

   state_t      r_state;
   logic [15:0] r_wdt;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_state     <= S_IDLE;
         r_wdt       <= '0;
         cmd_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= '0;
         rsp_err_o   <= 1'b0;
         rsp_tmo_o   <= 1'b0;
         CYC_O       <= 1'b0;
         STB_O       <= 1'b0;
         WE_O        <= 1'b0;
         ADR_O       <= '0;
         DAT_O       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid_i && cmd_ready_o) begin
                  cmd_ready_o <= 1'b0;
                  CYC_O       <= 1'b1;
                  STB_O       <= 1'b1;
                  WE_O        <= cmd_we_i;
                  ADR_O       <= cmd_adr_i;
                  DAT_O       <= cmd_dat_i;
                  r_wdt       <= WDT_LOAD;
                  r_state     <= S_BUS;
               end else begin
                  cmd_ready_o <= 1'b1;
               end
            end
            S_BUS: begin
               if (ACK_I || ERR_I) begin
                  CYC_O       <= 1'b0;
                  STB_O       <= 1'b0;
                  WE_O        <= 1'b0;
                  ADR_O       <= '0;
                  DAT_O       <= '0;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= ERR_I;
                  // ERR dominates a simultaneous ACK, so data is only returned on a clean read ACK
                  rsp_dat_o   <= (ACK_I && !ERR_I && !WE_O) ? DAT_I : '0;
                  r_state     <= S_RESP;
               end else if (r_wdt == 16'd0) begin
                  CYC_O       <= 1'b0;
                  STB_O       <= 1'b0;
                  WE_O        <= 1'b0;
                  ADR_O       <= '0;
                  DAT_O       <= '0;
                  rsp_valid_o <= 1'b1;
                  rsp_tmo_o   <= 1'b1;
                  rsp_dat_o   <= '0;
                  r_state     <= S_RESP;
               end else begin
                  r_wdt <= r_wdt - 16'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  rsp_dat_o   <= '0;
                  rsp_err_o   <= 1'b0;
                  rsp_tmo_o   <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed scenarios plus random transactions checked against a
// transaction-level model of strobe length and response contents.
`timescale 1ns/1ps

module tb_wb_cmd_master;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic          CLK_I = 1'b0;
   logic          RST_I;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic          cmd_we_i;
   logic [AW-1:0] cmd_adr_i;
   logic [DW-1:0] cmd_dat_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic [DW-1:0] rsp_dat_o;
   logic          rsp_err_o;
   logic          rsp_tmo_o;
   logic          CYC_O;
   logic          STB_O;
   logic          WE_O;
   logic [AW-1:0] ADR_O;
   logic [DW-1:0] DAT_O;
   logic          ACK_I;
   logic          ERR_I;
   logic [DW-1:0] DAT_I;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK_I = ~CLK_I;

   wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
      .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
      .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
      .ACK_I(ACK_I), .ERR_I(ERR_I), .DAT_I(DAT_I)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // kind: 0 = ACK, 1 = ERR, 2 = ACK+ERR together, 3 = silent responder.
   // w wait states means the responder answers on strobe cycle w+1.
   task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [31:0] rdata, input int w, input int kind,
                         input int dly, input bit late_ack);
      bit          ack_ok;
      int          e_stb;
      logic        e_err, e_tmo;
      logic [31:0] e_dat;
      int          stb_cnt;
      int          guard;

      ack_ok = (kind != 3) && (w + 1 <= TMO);
      e_stb  = ack_ok ? w + 1 : TMO;
      e_err  = ack_ok && (kind != 0);
      e_tmo  = !ack_ok;
      e_dat  = (ack_ok && kind == 0 && !we) ? rdata : 32'h0;

      guard = 0;
      while (!cmd_ready_o && guard < 50) begin
         @(negedge CLK_I);
         guard++;
      end
      chk("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);

      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_adr_i   = adr;
      cmd_dat_i   = dat;
      @(posedge CLK_I);
      @(negedge CLK_I);
      cmd_valid_i = 1'b0;
      cmd_we_i    = $urandom_range(0, 1);
      cmd_adr_i   = $urandom;
      cmd_dat_i   = $urandom;

      stb_cnt = 0;
      for (int i = 0; i < TMO + 20; i++) begin
         if (!STB_O) break;
         stb_cnt++;
         chk("bus_cyc_we_adr", {30'd0, CYC_O, WE_O, ADR_O}, {30'd0, 1'b1, we, adr});
         chk("bus_dat", 64'(DAT_O), 64'(dat));
         chk("cmd_ready_busy", 64'(cmd_ready_o), 64'd0);
         if (kind != 3 && stb_cnt == w + 1) begin
            ACK_I = (kind != 1);
            ERR_I = (kind != 0);
            DAT_I = rdata;
         end else begin
            ACK_I = 1'b0;
            ERR_I = 1'b0;
            DAT_I = $urandom;
         end
         @(negedge CLK_I);
      end
      ACK_I = 1'b0;
      ERR_I = 1'b0;
      chk("stb_cycles", 64'(stb_cnt), 64'(e_stb));
      chk("cyc_low_after", {62'd0, CYC_O, STB_O}, 64'd0);

      for (int i = 0; i < dly; i++) begin
         chk("rsp_valid_hold", 64'(rsp_valid_o), 64'd1);
         chk("rsp_fields_hold", {30'd0, rsp_err_o, rsp_tmo_o, rsp_dat_o}, {30'd0, e_err, e_tmo, e_dat});
         chk("cmd_ready_resp", {62'd0, cmd_ready_o, CYC_O}, 64'd0);
         cmd_valid_i = 1'b1;
         ACK_I = late_ack && (i == 1);
         @(negedge CLK_I);
      end
      ACK_I = 1'b0;
      chk("rsp_valid", 64'(rsp_valid_o), 64'd1);
      chk("rsp_fields", {30'd0, rsp_err_o, rsp_tmo_o, rsp_dat_o}, {30'd0, e_err, e_tmo, e_dat});

      rsp_ready_i = 1'b1;
      @(posedge CLK_I);
      @(negedge CLK_I);
      rsp_ready_i = 1'b0;
      cmd_valid_i = 1'b0;
      chk("rsp_cleared", {29'd0, rsp_valid_o, rsp_err_o, rsp_tmo_o, rsp_dat_o}, 64'd0);
      chk("back_idle", {62'd0, cmd_ready_o, CYC_O}, 64'd2);
   endtask

   initial begin
      RST_I = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0;
      rsp_ready_i = 1'b0; ACK_I = 1'b0; ERR_I = 1'b0; DAT_I = '0;
      repeat (3) @(negedge CLK_I);
      chk("reset_outputs", {26'd0, cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_tmo_o, CYC_O, STB_O, WE_O, |ADR_O, |DAT_O, |rsp_dat_o}, 64'd0);
      RST_I = 1'b0;
      @(negedge CLK_I);
      chk("ready_after_reset", 64'(cmd_ready_o), 64'd1);

      // Directed scenarios
      do_cmd(1'b1, 32'h10, 32'hA5A5_0001, 32'h0, 0, 0, 0, 1'b0);
      do_cmd(1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 3, 0, 0, 1'b0);
      do_cmd(1'b0, 32'h30, 32'h0, 32'h1234_5678, 1, 2, 1, 1'b0);
      do_cmd(1'b0, 32'h40, 32'h0, 32'h0, 0, 3, 4, 1'b1);
      do_cmd(1'b0, 32'h50, 32'h0, 32'hCAFE_F00D, 2, 0, 5, 1'b0);
      do_cmd(1'b1, 32'h60, 32'h5555_AAAA, 32'h0, TMO - 1, 0, 0, 1'b0);
      do_cmd(1'b0, 32'h64, 32'h0, 32'h0, TMO, 0, 1, 1'b0);

      // Responder strobes while the bus is idle must not produce anything
      ACK_I = 1'b1; ERR_I = 1'b1;
      repeat (2) @(negedge CLK_I);
      ACK_I = 1'b0; ERR_I = 1'b0;
      @(negedge CLK_I);
      chk("idle_ack_ignored", {61'd0, rsp_valid_o, CYC_O, cmd_ready_o}, 64'd1);

      // Reset in the middle of a bus cycle
      cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h70;
      @(posedge CLK_I);
      @(negedge CLK_I);
      cmd_valid_i = 1'b0;
      repeat (2) @(negedge CLK_I);
      chk("stb_before_reset", 64'(STB_O), 64'd1);
      RST_I = 1'b1;
      @(negedge CLK_I);
      chk("reset_mid_bus", {61'd0, CYC_O, STB_O, rsp_valid_o}, 64'd0);
      RST_I = 1'b0;
      repeat (TMO + 2) begin
         @(negedge CLK_I);
         chk("no_rsp_after_reset", {62'd0, rsp_valid_o, CYC_O}, 64'd0);
      end
      do_cmd(1'b0, 32'h74, 32'h0, 32'h0BAD_F00D, 1, 0, 0, 1'b0);

      // Random transactions
      for (int t = 0; t < 40; t++) begin
         int kind;
         kind = $urandom_range(0, 3);
         do_cmd($urandom_range(0, 1), $urandom, $urandom, $urandom,
                $urandom_range(0, TMO + 1), kind, $urandom_range(0, 3), $urandom_range(0, 1));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
